// File: rtl/axi4_lite_pkg.sv
// ============================================================================
// Module  : axi4_lite_pkg
// Brief   : Shared defaults, FSM encodings and address helper for the AXI4-Lite slave memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package axi4_lite_pkg;

   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_MEM_DEPTH  = 16;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_ADDR = 2'd1,
      W_DATA = 2'd2,
      W_RESP = 2'd3
   } wr_state_e;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_e;

   // Drop the byte offset, then keep only the index bits so accesses wrap.
   function automatic logic [31:0] addr_to_idx(input logic [63:0] addr,
                                               input int unsigned lsb,
                                               input int unsigned depth);
      logic [63:0] shifted;
      shifted = addr >> lsb;
      return shifted[31:0] & (depth - 32'd1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/axil_mem_array.sv
// ============================================================================
// Module  : axil_mem_array
// Brief   : MEM_DEPTH x DATA_WIDTH register file, async clear, byte-enable write,
//           combinational read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_mem_array #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 16,
   localparam int IDX_W     = $clog2(MEM_DEPTH),
   localparam int STRB_W    = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [STRB_W-1:0]     wr_be,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   for (genvar w = 0; w < MEM_DEPTH; w++) begin : g_word
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            mem[w] <= '0;
         end else if (we && (wr_idx == IDX_W'(w))) begin
            for (int b = 0; b < STRB_W; b++) begin
               if (wr_be[b]) begin
                  mem[w][b*8 +: 8] <= wr_data[b*8 +: 8];
               end
            end
         end
      end
   end

   // Read is pre-write: a same-edge write only lands after this value is sampled.
   assign rd_data = mem[rd_idx];

endmodule

`default_nettype wire

// File: rtl/axi4_lite_slave_mem.sv
// ============================================================================
// Module  : axi4_lite_slave_mem
// Brief   : AXI4-Lite slave endpoint backed by a word-addressed memory.
//           Optional macro AXIL_WSTRB_EN enables byte-lane write strobes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_lite_slave_mem
   import axi4_lite_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    WVALID,
   output logic                    WREADY,
   output logic                    BVALID,
   input  logic                    BREADY,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic                    RVALID,
   input  logic                    RREADY
);

   localparam int STRB_W   = DATA_WIDTH / 8;
   localparam int ADDR_LSB = $clog2(STRB_W);
   localparam int IDX_W    = $clog2(MEM_DEPTH);

   logic                  rst_done;
   wr_state_e             wr_state;
   wr_state_e             wr_next;
   rd_state_e             rd_state;
   rd_state_e             rd_next;
   logic                  aw_hs;
   logic                  w_hs;
   logic                  ar_hs;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] held_awaddr;
   logic [DATA_WIDTH-1:0] held_wdata;
   logic [ADDR_WIDTH-1:0] wr_addr_sel;
   logic [DATA_WIDTH-1:0] wr_data_sel;
   logic [STRB_W-1:0]     wr_be;
   logic [IDX_W-1:0]      wr_idx;
   logic [IDX_W-1:0]      rd_idx;
   logic [DATA_WIDTH-1:0] mem_rd_data;

   assign aw_hs = AWVALID && AWREADY;
   assign w_hs  = WVALID && WREADY;
   assign ar_hs = ARVALID && ARREADY;

   // Readies stay low for the first cycle after reset release.
   always_ff @(posedge ACLK or posedge ARESETn) begin
      if (ARESETn) rst_done <= 1'b0;
      else         rst_done <= 1'b1;
   end

   // ---------------- write FSM ----------------
   always_ff @(posedge ACLK or posedge ARESETn) begin
      if (ARESETn) wr_state <= W_IDLE;
      else         wr_state <= wr_next;
   end

   always_comb begin
      wr_next = wr_state;
      case (wr_state)
         W_IDLE: begin
            if (aw_hs && w_hs) wr_next = W_RESP;
            else if (aw_hs)    wr_next = W_ADDR;
            else if (w_hs)     wr_next = W_DATA;
         end
         W_ADDR:  if (w_hs)   wr_next = W_RESP;
         W_DATA:  if (aw_hs)  wr_next = W_RESP;
         W_RESP:  if (BREADY) wr_next = W_IDLE;
         default:             wr_next = W_IDLE;
      endcase
   end

   always_comb begin
      AWREADY = rst_done && ((wr_state == W_IDLE) || (wr_state == W_DATA));
      WREADY  = rst_done && ((wr_state == W_IDLE) || (wr_state == W_ADDR));
      BVALID  = (wr_state == W_RESP);
   end

   always_ff @(posedge ACLK or posedge ARESETn) begin
      if (ARESETn) begin
         held_awaddr <= '0;
         held_wdata  <= '0;
      end else begin
         if (aw_hs) held_awaddr <= AWADDR;
         if (w_hs)  held_wdata  <= WDATA;
      end
   end

   // Commit on the edge where the second half of the AW/W pair arrives.
   assign mem_we      = (wr_state != W_RESP) && (wr_next == W_RESP);
   assign wr_addr_sel = aw_hs ? AWADDR : held_awaddr;
   assign wr_data_sel = w_hs  ? WDATA  : held_wdata;
   assign wr_idx      = IDX_W'(addr_to_idx(64'(wr_addr_sel), ADDR_LSB, MEM_DEPTH));
   assign rd_idx      = IDX_W'(addr_to_idx(64'(ARADDR), ADDR_LSB, MEM_DEPTH));

`ifdef AXIL_WSTRB_EN
   logic [STRB_W-1:0] held_wstrb;

   always_ff @(posedge ACLK or posedge ARESETn) begin
      if (ARESETn)   held_wstrb <= '0;
      else if (w_hs) held_wstrb <= WSTRB;
   end

   assign wr_be = w_hs ? WSTRB : held_wstrb;
`else
   logic unused_wstrb;

   assign unused_wstrb = ^WSTRB;
   assign wr_be        = '1;
`endif

   axil_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_mem (
      .clk     (ACLK),
      .rst     (ARESETn),
      .we      (mem_we),
      .wr_idx  (wr_idx),
      .wr_data (wr_data_sel),
      .wr_be   (wr_be),
      .rd_idx  (rd_idx),
      .rd_data (mem_rd_data)
   );

   // ---------------- read FSM ----------------
   always_ff @(posedge ACLK or posedge ARESETn) begin
      if (ARESETn) rd_state <= R_IDLE;
      else         rd_state <= rd_next;
   end

   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         R_IDLE:  if (ar_hs)  rd_next = R_DATA;
         R_DATA:  if (RREADY) rd_next = R_IDLE;
         default:             rd_next = R_IDLE;
      endcase
   end

   always_comb begin
      ARREADY = rst_done && (rd_state == R_IDLE);
      RVALID  = (rd_state == R_DATA);
   end

   always_ff @(posedge ACLK or posedge ARESETn) begin
      if (ARESETn)    RDATA <= '0;
      else if (ar_hs) RDATA <= mem_rd_data;
   end

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_slave_mem.sv
// ============================================================================
// Module  : tb_axi4_lite_slave_mem
// Brief   : Directed self-checking bench for axi4_lite_slave_mem with a
//           transaction-level reference model (honours AXIL_WSTRB_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi4_lite_slave_mem;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] AWADDR = '0;
   logic        AWVALID = 1'b0;
   logic        AWREADY;
   logic [31:0] WDATA = '0;
   logic [3:0]  WSTRB = '0;
   logic        WVALID = 1'b0;
   logic        WREADY;
   logic        BVALID;
   logic        BREADY = 1'b0;
   logic [31:0] ARADDR = '0;
   logic        ARVALID = 1'b0;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic        RVALID;
   logic        RREADY = 1'b0;

   int n_vec = 0;
   int n_bad = 0;

   axi4_lite_slave_mem #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_DEPTH  (16)
   ) dut (
      .ACLK    (clk),
      .ARESETn (rst),
      .AWADDR  (AWADDR),
      .AWVALID (AWVALID),
      .AWREADY (AWREADY),
      .WDATA   (WDATA),
      .WSTRB   (WSTRB),
      .WVALID  (WVALID),
      .WREADY  (WREADY),
      .BVALID  (BVALID),
      .BREADY  (BREADY),
      .ARADDR  (ARADDR),
      .ARVALID (ARVALID),
      .ARREADY (ARREADY),
      .RDATA   (RDATA),
      .RVALID  (RVALID),
      .RREADY  (RREADY)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending-transaction flags and a word array.
   logic [31:0] m_mem [16];
   logic        m_rst_done = 1'b0;
   logic        m_aw_pend  = 1'b0;
   logic        m_w_pend   = 1'b0;
   logic        m_bvalid   = 1'b0;
   logic        m_rvalid   = 1'b0;
   logic [31:0] m_rdata    = '0;
   logic [31:0] m_awaddr   = '0;
   logic [31:0] m_wdata    = '0;
   logic [3:0]  m_wstrb    = '0;

   function automatic logic exp_awready();
      return m_rst_done && !m_aw_pend && !m_bvalid;
   endfunction
   function automatic logic exp_wready();
      return m_rst_done && !m_w_pend && !m_bvalid;
   endfunction
   function automatic logic exp_arready();
      return m_rst_done && !m_rvalid;
   endfunction

   task automatic model_step();
      logic aw_hs, w_hs, ar_hs;
      logic [31:0] old, nw;
      if (rst) begin
         for (int i = 0; i < 16; i++) m_mem[i] = '0;
         m_rst_done = 0; m_aw_pend = 0; m_w_pend = 0;
         m_bvalid = 0; m_rvalid = 0; m_rdata = '0;
         return;
      end
      aw_hs = AWVALID && exp_awready();
      w_hs  = WVALID && exp_wready();
      ar_hs = ARVALID && exp_arready();
      if (m_rvalid && RREADY) m_rvalid = 0;
      if (ar_hs) begin
         m_rvalid = 1;
         m_rdata  = m_mem[(ARADDR / 4) % 16];
      end
      if (m_bvalid && BREADY) m_bvalid = 0;
      if (aw_hs) begin m_aw_pend = 1; m_awaddr = AWADDR; end
      if (w_hs)  begin m_w_pend = 1; m_wdata = WDATA; m_wstrb = WSTRB; end
      if (m_aw_pend && m_w_pend) begin
         old = m_mem[(m_awaddr / 4) % 16];
`ifdef AXIL_WSTRB_EN
         for (int b = 0; b < 4; b++)
            nw[b*8 +: 8] = m_wstrb[b] ? m_wdata[b*8 +: 8] : old[b*8 +: 8];
`else
         nw = m_wdata;
`endif
         m_mem[(m_awaddr / 4) % 16] = nw;
         m_aw_pend = 0; m_w_pend = 0; m_bvalid = 1;
      end
      m_rst_done = 1;
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      check("cyc_awready", 32'(AWREADY), 32'(exp_awready()));
      check("cyc_wready",  32'(WREADY),  32'(exp_wready()));
      check("cyc_bvalid",  32'(BVALID),  32'(m_bvalid));
      check("cyc_arready", 32'(ARREADY), 32'(exp_arready()));
      check("cyc_rvalid",  32'(RVALID),  32'(m_rvalid));
      check("cyc_rdata",   RDATA,        m_rdata);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, n_bad=%0d", n_bad);
      $fatal(1, "watchdog");
   end

   task automatic aw_only(input logic [31:0] a, input string tag);
      int k;
      AWADDR = a; AWVALID = 1;
      for (k = 0; k < 50 && !AWREADY; k++) @(negedge clk);
      if (!AWREADY) check({tag, "_aw_timeout"}, 0, 1);
      @(negedge clk);
      AWVALID = 0; AWADDR = $urandom;
   endtask

   task automatic w_only(input logic [31:0] d, input logic [3:0] s, input string tag);
      int k;
      WDATA = d; WSTRB = s; WVALID = 1;
      for (k = 0; k < 50 && !WREADY; k++) @(negedge clk);
      if (!WREADY) check({tag, "_w_timeout"}, 0, 1);
      @(negedge clk);
      WVALID = 0; WDATA = $urandom; WSTRB = 4'($urandom);
   endtask

   task automatic aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
      int k;
      AWADDR = a; AWVALID = 1; WDATA = d; WSTRB = s; WVALID = 1;
      for (k = 0; k < 50 && !(AWREADY && WREADY); k++) @(negedge clk);
      if (!(AWREADY && WREADY)) check({tag, "_awW_timeout"}, 0, 1);
      @(negedge clk);
      AWVALID = 0; WVALID = 0; AWADDR = $urandom; WDATA = $urandom;
   endtask

   task automatic b_accept(input int hold, input string tag);
      int k;
      BREADY = 0;
      for (k = 0; k < 50 && !BVALID; k++) @(negedge clk);
      if (!BVALID) check({tag, "_b_timeout"}, 0, 1);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({tag, "_b_held"}, 32'(BVALID), 1);
         check({tag, "_aw_blocked"}, 32'(AWREADY), 0);
         check({tag, "_w_blocked"}, 32'(WREADY), 0);
      end
      BREADY = 1;
      @(negedge clk);
      BREADY = 0;
      check({tag, "_b_done"}, 32'(BVALID), 0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
      aw_w(a, d, s, tag);
      check({tag, "_bvalid_next"}, 32'(BVALID), 1);
      b_accept(0, tag);
   endtask

   task automatic rd(input logic [31:0] a, input int hold, input logic [31:0] exp, input string tag);
      int k;
      ARADDR = a; ARVALID = 1; RREADY = 0;
      for (k = 0; k < 50 && !ARREADY; k++) @(negedge clk);
      if (!ARREADY) check({tag, "_ar_timeout"}, 0, 1);
      @(negedge clk);
      ARVALID = 0; ARADDR = $urandom;
      check({tag, "_rvalid"}, 32'(RVALID), 1);
      check({tag, "_rdata"}, RDATA, exp);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({tag, "_rvalid_held"}, 32'(RVALID), 1);
         check({tag, "_rdata_held"}, RDATA, exp);
         check({tag, "_ar_blocked"}, 32'(ARREADY), 0);
      end
      RREADY = 1;
      @(negedge clk);
      RREADY = 0;
      check({tag, "_r_done"}, 32'(RVALID), 0);
      check({tag, "_ar_free"}, 32'(ARREADY), 1);
   endtask

   initial begin
      logic [31:0] exp_t5;
      // 1. reset
      repeat (2) @(negedge clk);
      check("rst_awready", 32'(AWREADY), 0);
      check("rst_bvalid",  32'(BVALID), 0);
      check("rst_rdata",   RDATA, 0);
      #2 rst = 0;
      #1 check("rel_awready_low", 32'(AWREADY), 0);
      @(negedge clk);
      check("rel_awready", 32'(AWREADY), 1);
      check("rel_wready",  32'(WREADY), 1);
      check("rel_arready", 32'(ARREADY), 1);

      // 2. AW+W same cycle, then read back
      wr(32'h04, 32'hDEADBEEF, 4'hF, "t2");
      rd(32'h04, 0, 32'hDEADBEEF, "t2r");

      // 3. W first, AW later, held response
      w_only(32'h12345678, 4'hF, "t3");
      check("t3_no_b_yet", 32'(BVALID), 0);
      check("t3_aw_open", 32'(AWREADY), 1);
      check("t3_w_closed", 32'(WREADY), 0);
      repeat (2) @(negedge clk);
      aw_only(32'h08, "t3");
      check("t3_bvalid", 32'(BVALID), 1);
      b_accept(4, "t3");

      // 4. read back-pressure
      rd(32'h08, 3, 32'h12345678, "t4");

      // 5. strobes
`ifdef AXIL_WSTRB_EN
      exp_t5 = 32'hFFFF0000;
`else
      exp_t5 = 32'h00000000;
`endif
      wr(32'h0C, 32'hFFFFFFFF, 4'hF, "t5a");
      wr(32'h0C, 32'h00000000, 4'h3, "t5b");
      rd(32'h0C, 0, exp_t5, "t5r");

      // 6. wrap, then reset mid-write
      wr(32'h40, 32'hA5A5A5A5, 4'hF, "t6");
      rd(32'h00, 0, 32'hA5A5A5A5, "t6r");
      rd(32'h04, 0, 32'hDEADBEEF, "t6k");
      aw_only(32'h14, "t6m");
      check("t6m_pending_no_b", 32'(BVALID), 0);
      #2 rst = 1;
      #1 check("t6m_rst_awready", 32'(AWREADY), 0);
      check("t6m_rst_wready", 32'(WREADY), 0);
      WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1;
      repeat (2) @(negedge clk);
      #2 rst = 0;
      @(negedge clk);
      WVALID = 0;
      repeat (3) begin
         @(negedge clk);
         check("t6m_no_b", 32'(BVALID), 0);
      end
      rd(32'h14, 0, 32'h00000000, "t6z");
      rd(32'h00, 0, 32'h00000000, "t6c");

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
